demorgan_adder: RTL and testbench

//   Registered ripple-carry adder whose sum and carry logic is written in De Morgan
//   (NAND/NOR) form, so the synthesis flow's De Morgan/reduce optimisation can

---
 rtl/demorgan_pkg.sv | 17 +
 rtl/demorgan_adder_fa_cell.sv | 21 ++
 rtl/demorgan_adder.sv | 72 +++++++
 tb/tb_demorgan_adder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan ripple-carry adder: reset value and
// NAND/NOR-form bit functions used by the full-adder cell.
package demorgan_pkg;

    localparam logic DM_RESET_VAL = 1'b0;

    // XOR expressed purely as inverted ANDs so the synthesis flow can fold it back.
    function automatic logic dm_xor(input logic a, input logic b);
        return ~(~(a & ~b) & ~(~a & b));
    endfunction

    // Majority: generate (a&b) or propagate the incoming carry through a^b.
    function automatic logic dm_maj(input logic a, input logic b, input logic c);
        return ~(~(a & b) & ~(c & dm_xor(a, b)));
    endfunction

endpackage

// File: rtl/demorgan_adder_fa_cell.sv
// One-bit combinational full adder in NAND/NOR form (module demorgan_fa_cell).
module demorgan_fa_cell
    import demorgan_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_s;

    // Propagate, sum and carry-out of a single bit
    always_comb begin
        p_s = dm_xor(a, b);
        s   = dm_xor(p_s, ci);
        co  = dm_maj(a, b, ci);
    end

endmodule

// File: rtl/demorgan_adder.sv
// Registered ripple-carry adder {cout,A} = x + y + cin, one cycle latency.
// Optional DEMORGAN_XCHECK_EN adds a sticky xchk_err flag from a redundant direct adder.
module demorgan_adder
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] A,
    output logic             cout
`ifdef DEMORGAN_XCHECK_EN
    ,
    output logic             xchk_err
`endif
);

    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] s_s;

    assign c_s[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            demorgan_fa_cell u_fa (
                .a  (x[i]),
                .b  (y[i]),
                .ci (c_s[i]),
                .s  (s_s[i]),
                .co (c_s[i+1])
            );
        end
    endgenerate

    // Output registers; reset wins over any input in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            A    <= {WIDTH{DM_RESET_VAL}};
            cout <= DM_RESET_VAL;
        end else begin
            A    <= s_s;
            cout <= c_s[WIDTH];
        end
    end

`ifdef DEMORGAN_XCHECK_EN
    logic [WIDTH:0] direct_s;
    logic           mismatch_s;

    // Independent reference sum compared against the gate-level chain
    always_comb begin
        direct_s   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        mismatch_s = (direct_s != {c_s[WIDTH], s_s});
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            xchk_err <= DM_RESET_VAL;
        end else if (mismatch_s) begin
            xchk_err <= 1'b1;
        end else begin
            xchk_err <= xchk_err;
        end
    end
`endif

endmodule

// File: tb/tb_demorgan_adder.sv
// Scoreboard bench for demorgan_adder at WIDTH=1, 4 and 8 driven from shared stimulus.
module tb_demorgan_adder;

    typedef struct {
        logic [8:0] exp;
        int         due;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] x   = 8'd0;
    logic [7:0] y   = 8'd0;
    logic       cin = 1'b0;

    logic       a1, co1;
    logic [3:0] a4;
    logic       co4;
    logic [7:0] a8;
    logic       co8;
`ifdef DEMORGAN_XCHECK_EN
    logic       xe1, xe4, xe8;
`endif

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;
    entry_t q1[$];
    entry_t q4[$];
    entry_t q8[$];

    // {cin,y,x} = 0..7 truth tables for a 1-bit full adder
    logic [7:0] sum_tbl   = 8'b1001_0110;
    logic [7:0] carry_tbl = 8'b1110_1000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demorgan_adder #(.WIDTH(1)) d1 (
        .clk(clk), .rst(rst), .x(x[0]), .y(y[0]), .cin(cin), .A(a1), .cout(co1)
`ifdef DEMORGAN_XCHECK_EN
        , .xchk_err(xe1)
`endif
    );
    demorgan_adder #(.WIDTH(4)) d4 (
        .clk(clk), .rst(rst), .x(x[3:0]), .y(y[3:0]), .cin(cin), .A(a4), .cout(co4)
`ifdef DEMORGAN_XCHECK_EN
        , .xchk_err(xe4)
`endif
    );
    demorgan_adder #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .x(x), .y(y), .cin(cin), .A(a8), .cout(co8)
`ifdef DEMORGAN_XCHECK_EN
        , .xchk_err(xe8)
`endif
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare entries whose due cycle has come
    always @(negedge clk) begin
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            check("w1", {7'd0, co1, a1}, q1[0].exp);
            void'(q1.pop_front());
        end
        while (q4.size() > 0 && q4[0].due <= cyc) begin
            check("w4", {4'd0, co4, a4}, q4[0].exp);
            void'(q4.pop_front());
        end
        while (q8.size() > 0 && q8[0].due <= cyc) begin
            check("w8", {co8, a8}, q8[0].exp);
`ifdef DEMORGAN_XCHECK_EN
            check("xchk", {6'd0, xe1, xe4, xe8}, 9'd0);
`endif
            void'(q8.pop_front());
        end
    end

    // Drive one vector; W1 expected from truth table, W4 given explicitly, W8 from x+y+cin
    task automatic step(input logic r, input logic [7:0] xv, input logic [7:0] yv,
                        input logic c, input logic [4:0] exp4);
        entry_t e;
        logic [2:0] idx;
        @(posedge clk);
        #1;
        rst = r; x = xv; y = yv; cin = c;
        idx = {c, yv[0], xv[0]};
        e.due = cyc + 1;
        e.exp = r ? 9'd0 : {7'd0, carry_tbl[idx], sum_tbl[idx]};
        q1.push_back(e);
        e.exp = r ? 9'd0 : {4'd0, exp4};
        q4.push_back(e);
        e.exp = r ? 9'd0 : ({1'b0, xv} + {1'b0, yv} + {8'd0, c});
        q8.push_back(e);
    endtask

    function automatic logic [4:0] m4(input logic [7:0] xv, input logic [7:0] yv, input logic c);
        return {1'b0, xv[3:0]} + {1'b0, yv[3:0]} + {4'd0, c};
    endfunction

    initial begin
        logic [7:0] rx, ry;
        logic       rc;
        int         guard;

        // Reset held two cycles with all-ones inputs
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 5'd0);
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 5'd0);

        // Exhaustive 1-bit sweep of {cin,y,x}
        for (int i = 0; i < 10000; i++) begin
            logic [2:0] k;
            k = 3'(i % 8);
            step(1'b0, {7'd0, k[0]}, {7'd0, k[1]}, k[2], m4({7'd0, k[0]}, {7'd0, k[1]}, k[2]));
        end

        // Wrap-around then all-zeros
        step(1'b0, 8'h0F, 8'h0F, 1'b1, 5'h1F);
        step(1'b0, 8'h00, 8'h00, 1'b0, 5'h00);
        step(1'b0, 8'hFF, 8'hFF, 1'b1, 5'h1F);

        // Mid-stream reset: 3+5 held, reset for one edge, then 8 appears
        step(1'b0, 8'h03, 8'h05, 1'b0, 5'h08);
        step(1'b1, 8'h03, 8'h05, 1'b0, 5'h00);
        step(1'b0, 8'h03, 8'h05, 1'b0, 5'h08);
        step(1'b0, 8'h0A, 8'h07, 1'b1, 5'h12);

        // Random vectors
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            step(1'b0, rx, ry, rc, m4(rx, ry, rc));
        end

        // Final reset clears everything, including the sticky flag
        step(1'b1, 8'h55, 8'hAA, 1'b1, 5'd0);
        step(1'b0, 8'h00, 8'h01, 1'b0, 5'h01);

        guard = 0;
        while ((q1.size() + q4.size() + q8.size()) > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        if ((q1.size() + q4.size() + q8.size()) > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", q1.size() + q4.size() + q8.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
